reg_bus_master: RTL and testbench

- Bus initiator that sequences CS/W/R strobes into a bank of 16-bit chip-selected registers (the storage cells of the register file).
- Accepts read/write requests on a valid/ready request channel and drives one-hot chip selects, the shared write-data bus and the W/R strobes.
- Captures the selected register's read output and returns it on a valid/ready response channel.
- Sits between the datapath control logic and the register file.

---
 rtl/reg_bus_master.sv | 121 ++++++++++++
 tb/tb_reg_bus_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_bus_master
// Purpose  : Sequences CS/W/R strobes into a bank of chip-selected registers
//            from a valid/ready request channel, with a valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_master #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WE,
  input  logic [AW-1:0]      REQ_ADDR,
  input  logic [DW-1:0]      REQ_WDATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [DW-1:0]      RSP_RDATA,
  output logic               RSP_ERR,
  output logic [NREG-1:0]    BUS_CS,
  output logic               BUS_W,
  output logic               BUS_R,
  output logic [DW-1:0]      BUS_D,
  input  logic [NREG*DW-1:0] BUS_Q
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_setup  = 2'd1;
  localparam logic [1:0] c_strobe = 2'd2;
  localparam logic [1:0] c_resp   = 2'd3;
  localparam int unsigned c_nreg  = NREG;

  logic [1:0]      r_state;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_err;

  logic            w_legal;
  logic            w_active;
  logic [NREG-1:0] w_cs;
  logic [DW-1:0]   w_q_sel;

  assign w_legal  = 32'(REQ_ADDR) < c_nreg;
  assign w_active = (r_state == c_setup) || (r_state == c_strobe);

  always_comb begin
    w_cs    = '0;
    w_q_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_addr == AW'(i)) begin
        w_cs[i] = 1'b1;
        w_q_sel = BUS_Q[i*DW +: DW];
      end
    end
  end

  // Bus outputs decode straight from state so reset removes them without an edge
  assign BUS_CS    = w_active ? w_cs : '0;
  assign BUS_D     = (w_active && r_we) ? r_wdata : '0;
  assign BUS_W     = (r_state == c_strobe) && r_we;
  assign BUS_R     = (r_state == c_strobe) && !r_we;
  assign REQ_READY = (r_state == c_idle);
  assign RSP_VALID = (r_state == c_resp);
  assign RSP_RDATA = r_rdata;
  assign RSP_ERR   = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_idle;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (REQ_VALID) begin
            r_we    <= REQ_WE;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_rdata <= '0;
            if (w_legal) begin
              r_err   <= 1'b0;
              r_state <= c_setup;
            end else begin
              // Out-of-range addresses skip the bus and answer at once
              r_err   <= 1'b1;
              r_state <= c_resp;
            end
          end
        end
        c_setup: begin
          r_state <= c_strobe;
        end
        c_strobe: begin
          if (!r_we) begin
            r_rdata <= w_q_sel;
          end
          r_state <= c_resp;
        end
        default: begin
          if (RSP_READY) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= c_idle;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for reg_bus_master: directed vector table, hand-written
// reset/backpressure sequences and randomized traffic against a register model.
module tb_reg_bus_master;
  localparam int NREG = 8;
  localparam int AW   = 4;
  localparam int DW   = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    logic [DW-1:0] rdata;
    logic          err;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  logic REQ_VALID, REQ_READY, REQ_WE;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;
  logic RSP_VALID, RSP_READY, RSP_ERR;
  logic [DW-1:0] RSP_RDATA;
  logic [NREG-1:0] BUS_CS;
  logic BUS_W, BUS_R;
  logic [DW-1:0] BUS_D;
  logic [NREG*DW-1:0] BUS_Q;

  // Second instance with a partially populated address space
  logic rv6, rr6, we6, sv6, sr6, er6, w6, r6;
  logic [2:0] addr6;
  logic [DW-1:0] wd6, rd6, d6;
  logic [5:0] cs6;
  logic [6*DW-1:0] q6;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] bank [NREG] = '{default: '0};
  logic [DW-1:0] exp_mem [NREG] = '{default: '0};
  logic [NREG-1:0] allowed_cs = '0;
  vec_t vecs [$];

  always #5 CLK = ~CLK;

  reg_bus_master #(.NREG(NREG), .AW(AW), .DW(DW)) u_dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .BUS_CS(BUS_CS), .BUS_W(BUS_W), .BUS_R(BUS_R),
    .BUS_D(BUS_D), .BUS_Q(BUS_Q)
  );

  reg_bus_master #(.NREG(6), .AW(3), .DW(DW)) u_dut6 (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(rv6), .REQ_READY(sr6), .REQ_WE(we6),
    .REQ_ADDR(addr6), .REQ_WDATA(wd6),
    .RSP_VALID(sv6), .RSP_READY(rr6), .RSP_RDATA(rd6),
    .RSP_ERR(er6), .BUS_CS(cs6), .BUS_W(w6), .BUS_R(r6),
    .BUS_D(d6), .BUS_Q(q6)
  );

  assign q6 = '0;

  // Register file environment: stores on W with the selected CS
  always_comb begin
    BUS_Q = '0;
    for (int i = 0; i < NREG; i++) BUS_Q[i*DW +: DW] = bank[i];
  end

  always @(posedge CLK) begin
    if (BUS_W) begin
      for (int i = 0; i < NREG; i++) if (BUS_CS[i]) bank[i] <= BUS_D;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      chk("w_r_exclusive", 32'(BUS_W & BUS_R), 32'd0);
      if (BUS_CS != '0) chk("cs_target", 32'(BUS_CS), 32'(allowed_cs));
      chk("dut6_bus_quiet", 32'({cs6, w6, r6}), 32'd0);
    end
  end

  function automatic logic is_legal(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  task automatic model_rsp(input logic we, input logic [AW-1:0] a,
                           output logic [DW-1:0] rd, output logic er);
    er = !is_legal(a);
    rd = (!er && !we) ? exp_mem[a[2:0]] : '0;
  endtask

  task automatic model_update(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we && is_legal(a)) exp_mem[a[2:0]] = d;
  endtask

  // Starts just after the edge that accepted the request
  task automatic post_accept(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input int hold, input bit bp_next,
                             input logic [DW-1:0] erd, input logic eer);
    logic [NREG-1:0] cs_exp;
    logic [DW-1:0] d_exp;
    cs_exp = is_legal(a) ? (NREG'(1) << a) : '0;
    d_exp  = we ? wd : '0;
    if (is_legal(a)) begin
      chk("setup_cs", 32'(BUS_CS), 32'(cs_exp));
      chk("setup_d", 32'(BUS_D), 32'(d_exp));
      chk("setup_wr", 32'({BUS_W, BUS_R}), 32'd0);
      chk("setup_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("setup_req_ready", 32'(REQ_READY), 32'd0);
      @(posedge CLK); #1;
      chk("strobe_cs", 32'(BUS_CS), 32'(cs_exp));
      chk("strobe_d", 32'(BUS_D), 32'(d_exp));
      chk("strobe_w", 32'(BUS_W), 32'(we));
      chk("strobe_r", 32'(BUS_R), 32'(!we));
      chk("strobe_rsp_valid", 32'(RSP_VALID), 32'd0);
      @(posedge CLK); #1;
    end else begin
      chk("err_bus_idle", 32'({BUS_CS, BUS_W, BUS_R}), 32'd0);
    end
    chk("rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("rsp_rdata", 32'(RSP_RDATA), 32'(erd));
    chk("rsp_err", 32'(RSP_ERR), 32'(eer));
    chk("rsp_req_ready", 32'(REQ_READY), 32'd0);
    chk("rsp_bus_idle", 32'({BUS_CS, BUS_W, BUS_R, BUS_D}), 32'd0);
    if (bp_next) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = '0; REQ_WDATA = 16'h0bad;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("hold_valid", 32'(RSP_VALID), 32'd1);
      chk("hold_rdata", 32'(RSP_RDATA), 32'(erd));
      chk("hold_err", 32'(RSP_ERR), 32'(eer));
      chk("hold_req_ready", 32'(REQ_READY), 32'd0);
      chk("hold_cs", 32'(BUS_CS), 32'd0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk("done_valid", 32'(RSP_VALID), 32'd0);
    chk("done_rdata", 32'(RSP_RDATA), 32'd0);
    chk("done_err", 32'(RSP_ERR), 32'd0);
    chk("done_req_ready", 32'(REQ_READY), 32'd1);
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int hold, input bit bp_next,
                      input logic [DW-1:0] erd, input logic eer);
    int n = 0;
    while (!REQ_READY && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("req_ready_wait", 32'(REQ_READY), 32'd1);
    allowed_cs = is_legal(a) ? (NREG'(1) << a) : '0;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    post_accept(we, a, wd, hold, bp_next, erd, eer);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, erd;
    logic eer;

    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    RSP_READY = 1'b0;
    rv6 = 1'b0; rr6 = 1'b0; we6 = 1'b0; addr6 = '0; wd6 = '0;
    #2;
    chk("reset_req_ready", 32'(REQ_READY), 32'd1);
    chk("reset_outputs", 32'({RSP_VALID, RSP_ERR, BUS_W, BUS_R, BUS_CS}), 32'd0);
    chk("reset_data", 32'({BUS_D, RSP_RDATA}), 32'd0);
    #20 RST = 1'b0;

    // Reset pulse in the middle of a cycle while a request is in SETUP
    @(posedge CLK); #1;
    allowed_cs = 8'b0000_0010;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 4'd1; REQ_WDATA = 16'h1111;
    @(posedge CLK); #1;
    chk("pre_reset_cs", 32'(BUS_CS), 32'h2);
    #2 RST = 1'b1;
    #1;
    REQ_VALID = 1'b0;
    chk("async_reset_ready", 32'(REQ_READY), 32'd1);
    chk("async_reset_bus", 32'({BUS_CS, BUS_W, BUS_R, BUS_D, RSP_VALID}), 32'd0);
    #3 RST = 1'b0;
    allowed_cs = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      chk("idle_after_reset", 32'({BUS_CS, RSP_VALID, ~REQ_READY}), 32'd0);
    end

    // Directed vectors
    vecs.push_back('{1'b1, 4'd2, 16'd325, 0, 16'd0, 1'b0});
    vecs.push_back('{1'b0, 4'd2, 16'd0, 0, 16'd325, 1'b0});
    for (int i = 0; i < NREG; i++)
      vecs.push_back('{1'b1, AW'(i), 16'(724 + i), 0, 16'd0, 1'b0});
    for (int i = NREG - 1; i >= 0; i--)
      vecs.push_back('{1'b0, AW'(i), 16'd0, 1, 16'(724 + i), 1'b0});
    vecs.push_back('{1'b1, 4'd5, 16'd4362, 0, 16'd0, 1'b0});
    vecs.push_back('{1'b0, 4'd9, 16'd0, 0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 4'd15, 16'd1234, 2, 16'd0, 1'b1});
    foreach (vecs[i]) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, 1'b0,
           vecs[i].rdata, vecs[i].err);
      model_update(vecs[i].we, vecs[i].addr, vecs[i].wdata);
    end

    // Backpressure with a competing request held on the request channel
    send(1'b0, 4'd5, 16'd0, 6, 1'b1, 16'd4362, 1'b0);
    allowed_cs = 8'b0000_0001;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    post_accept(1'b1, 4'd0, 16'h0bad, 0, 1'b0, 16'd0, 1'b0);
    model_update(1'b1, 4'd0, 16'h0bad);

    // Reset during the STROBE cycle of a read
    allowed_cs = 8'b0000_1000;
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'd3;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("strobe_before_reset", 32'({BUS_CS, BUS_R}), 32'({8'h08, 1'b1}));
    #2 RST = 1'b1;
    #1;
    chk("strobe_reset_drop", 32'({BUS_CS, BUS_R, RSP_VALID}), 32'd0);
    #4 RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      chk("no_rsp_after_reset", 32'(RSP_VALID), 32'd0);
    end
    model_rsp(1'b0, 4'd3, erd, eer);
    send(1'b0, 4'd3, 16'd0, 0, 1'b0, erd, eer);

    // Illegal address on the 6-register instance
    rv6 = 1'b1; we6 = 1'b0; addr6 = 3'd7;
    @(posedge CLK); #1;
    rv6 = 1'b0;
    chk("dut6_err_valid", 32'(sv6), 32'd1);
    chk("dut6_err_flag", 32'(er6), 32'd1);
    chk("dut6_err_rdata", 32'(rd6), 32'd0);
    chk("dut6_err_ready", 32'(sr6), 32'd0);
    rr6 = 1'b1;
    @(posedge CLK); #1;
    rr6 = 1'b0;
    chk("dut6_err_done", 32'({sv6, er6, ~sr6}), 32'd0);

    // Randomized traffic against the register model
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 9));
      wd = 16'($urandom);
      model_rsp(we, a, erd, eer);
      send(we, a, wd, int'($urandom_range(0, 2)), 1'b0, erd, eer);
      model_update(we, a, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
